// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch-stage FSM driving the ProgramCounter and instruction memory
module fetch_sequencer #(
   parameter int XLEN     = 32,
   parameter int MAX_WAIT = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_in,
   output logic            pc_en,
   output logic            pc_jmp,
   output logic [XLEN-1:0] pc_imm,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_imm,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst_data,
   output logic [XLEN-1:0] inst_pc,
   output logic            fetch_err
);
   localparam int CW = $clog2(MAX_WAIT);
   typedef enum logic [2:0] {IDLE, REQ, DRAIN, HOLD, ERR} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic [XLEN-1:0] addr_q;
   logic busy, timeout, redir, handoff;
   assign busy      = state == REQ || state == DRAIN;
   assign timeout   = busy && !imem_ack && cnt == CW'(MAX_WAIT - 1);
   assign redir     = redirect_valid && (busy || state == HOLD);
   assign handoff   = state == HOLD && inst_ready && !redirect_valid;
   assign pc_en     = redir || handoff;
   assign pc_jmp    = redir;
   assign pc_imm    = redir ? redirect_imm : '0;
   assign imem_addr = addr_q;
   // next state: a redirect that coincides with an ack re-latches the new PC through IDLE
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = REQ;
         REQ:     state_n = imem_ack ? (redirect_valid ? IDLE : HOLD) : timeout ? ERR : redirect_valid ? DRAIN : REQ;
         DRAIN:   state_n = imem_ack ? (redirect_valid ? IDLE : REQ) : timeout ? ERR : DRAIN;
         HOLD:    state_n = redirect_valid ? IDLE : inst_ready ? REQ : HOLD;
         default: state_n = ERR;
      endcase
   end
   // state, wait counter, fetch address and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         addr_q     <= '0;
         imem_req   <= 1'b0;
         inst_valid <= 1'b0;
         inst_data  <= '0;
         inst_pc    <= '0;
         fetch_err  <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= (busy && !imem_ack && state_n != ERR) ? cnt + 1'b1 : '0;
         imem_req   <= state_n == REQ || state_n == DRAIN;
         inst_valid <= state_n == HOLD;
         fetch_err  <= state_n == ERR;
         if (state == IDLE || (state == DRAIN && imem_ack))
            addr_q <= pc_in;
         else if (handoff)
            addr_q <= pc_in + XLEN'(4);
         if (state == REQ && imem_ack && !redirect_valid) begin
            inst_data <= imem_rdata;
            inst_pc   <= addr_q;
         end
      end
   end
endmodule
